// File: rtl/stream_dmux2.sv
// Registered 1:2 stream demultiplexer: each input word is steered by in_sel into
// one of two small FIFOs, each drained by its own independent valid/ready port.

module stream_dmux2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     occ
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (occ_q == OW'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && out_valid;
  assign occ       = occ_q;
  // Empty FIFO shows zero rather than stale storage.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage is masked by occupancy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module stream_dmux2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic [$clog2(DEPTH):0] occ0,
  output logic [$clog2(DEPTH):0] occ1
);
  logic full0;
  logic full1;
  logic push;
  logic push0;
  logic push1;

  // Ready looks only at registered occupancy; no combinational path from out*_ready.
  assign in_ready = in_sel ? !full1 : !full0;
  // in_valid gates first so an unknown in_sel on an idle cycle cannot reach state.
  assign push     = in_valid && in_ready;
  assign push0    = push && !in_sel;
  assign push1    = push && in_sel;

  stream_dmux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .occ       (occ0)
  );

  stream_dmux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .occ       (occ1)
  );
endmodule

// File: tb/tb_stream_dmux2.sv
// Directed and scoreboarded checks for stream_dmux2 (WIDTH=8, DEPTH=2).

module tb_stream_dmux2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       occ0;
  logic [1:0]       occ1;

  int total = 0;
  int bad   = 0;

  stream_dmux2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .occ0       (occ0),
    .occ1       (occ1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven right after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  initial begin
    int accepted;
    int cycles;
    logic e_rdy;
    logic p0, p1;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_d1", out1_data, 0);
    chk("rst_occ0", occ0, 0);
    chk("rst_occ1", occ1, 0);
    tick();

    // A5 to out0 then 3C to out1, both consumers ready
    drive(1'b1, 1'b0, 8'hA5);
    @(negedge clk);
    chk("a5_rdy", in_ready, 1);
    chk("a5_v0_before", out0_valid, 0);
    tick();
    drive(1'b1, 1'b1, 8'h3C);
    @(negedge clk);
    chk("a5_v0", out0_valid, 1);
    chk("a5_d0", out0_data, 8'hA5);
    chk("a5_occ0", occ0, 1);
    chk("3c_v1_before", out1_valid, 0);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("a5_v0_gone", out0_valid, 0);
    chk("3c_v1", out1_valid, 1);
    chk("3c_d1", out1_data, 8'h3C);
    tick();
    @(negedge clk);
    chk("3c_v1_gone", out1_valid, 0);
    chk("3c_occ1", occ1, 0);
    tick();

    // Fill out0 while stalled; out1 still accepts
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b1, 1'b0, 8'h22);
    @(negedge clk);
    chk("fill_occ0_1", occ0, 1);
    chk("fill_rdy_1", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 8'h99);
    @(negedge clk);
    chk("full_occ0", occ0, 2);
    chk("full_rdy_sel0", in_ready, 0);
    tick();
    @(negedge clk);
    chk("full_hold_occ0", occ0, 2);
    drive(1'b1, 1'b1, 8'h33);
    #1;
    chk("full_rdy_sel1", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("33_v1", out1_valid, 1);
    chk("33_d1", out1_data, 8'h33);
    chk("33_occ0", occ0, 2);
    chk("33_head0", out0_data, 8'h11);
    tick();
    @(negedge clk);
    chk("33_gone", occ1, 0);

    // Drain out0
    out0_ready = 1'b1;
    #1;
    chk("drain_rdy0_pre", in_ready, 0);
    tick();
    @(negedge clk);
    chk("drain_d0_2", out0_data, 8'h22);
    chk("drain_occ0_1", occ0, 1);
    chk("drain_rdy0", in_ready, 1);
    tick();
    @(negedge clk);
    chk("drain_v0", out0_valid, 0);
    chk("drain_occ0_0", occ0, 0);
    tick();

    // Steady stream on out1: push and pop together, pointer wraps
    out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      @(negedge clk);
      chk("strm_rdy", in_ready, 1);
      if (i > 0) begin
        chk("strm_occ1", occ1, 1);
        chk("strm_d1", out1_data, 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("strm_last", out1_data, 8'h07);
    chk("strm_last_occ", occ1, 1);
    tick();
    @(negedge clk);
    chk("strm_empty", occ1, 0);
    tick();

    // Reset with two words queued
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h5A);
    tick();
    drive(1'b1, 1'b1, 8'hC3);
    tick();
    drive(1'b0, 1'bx, 8'hxx);
    @(negedge clk);
    chk("q2_occ0", occ0, 1);
    chk("q2_occ1", occ1, 1);
    tick();
    @(negedge clk);
    chk("xsel_occ0", occ0, 1);
    chk("xsel_occ1", occ1, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_v0", out0_valid, 0);
    chk("mrst_v1", out1_valid, 0);
    chk("mrst_occ0", occ0, 0);
    chk("mrst_occ1", occ1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    tick();

    // Random traffic against a queue scoreboard
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = 8'($urandom);
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      e_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk("rnd_rdy", in_ready, e_rdy);
      chk("rnd_occ0", occ0, q0.size());
      chk("rnd_occ1", occ1, q1.size());
      chk("rnd_v0", out0_valid, q0.size() != 0);
      chk("rnd_v1", out1_valid, q1.size() != 0);
      chk("rnd_d0", out0_data, (q0.size() != 0) ? q0[0] : 8'h00);
      chk("rnd_d1", out1_data, (q1.size() != 0) ? q1[0] : 8'h00);
      p0 = out0_ready && (q0.size() != 0);
      p1 = out1_ready && (q1.size() != 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (in_valid && e_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        accepted++;
      end
      tick();
      cycles++;
    end
    chk("rnd_timeout", cycles < 20000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_dmux2.md
Name: stream_dmux2

Overview:
- Registered 1:2 stream demultiplexer: the clocked front end that feeds the combinational 1:2 dmux stage when the design moves from single-bit signals to word streams.
- Accepts one word per cycle on a valid/ready input, with a per-word select bit.
- Steers each word into a small per-output FIFO.
- Presents each output as an independent valid/ready stream, so a stalled consumer on one output never corrupts or drops data bound for the other.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 2, entries per output FIFO; power of two, >=2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word addressed by in_sel.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 -> out0, 1 -> out1.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  out0 consumer accepts head word.
- out0_data  output  WIDTH  out0 head word.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  out1 consumer accepts head word.
- out1_data  output  WIDTH  out1 head word.
- occ0  output  $clog2(DEPTH)+1  out0 FIFO occupancy.
- occ1  output  $clog2(DEPTH)+1  out1 FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk release):
  - all read/write pointers and occupancies are 0;
  - out0_valid=out1_valid=0; out0_data=out1_data=0; occ0=occ1=0;
  - in_ready = 1.
  - FIFO storage is not reset; it is masked by occupancy.
  - Reset mid-operation discards all queued words immediately.
- in_ready:
  - equals NOT full of the FIFO selected by the current in_sel;
  - depends only on registered occupancy and in_sel, never on out*_ready (no pass-through path);
  - a full out0 does not block words with in_sel=1.
- Push: occurs when in_valid && in_ready at a rising edge. in_data is written at the write pointer of FIFO[in_sel]; that pointer and its occupancy increment.
- Pop: occurs on outN when outN_valid && outN_ready at a rising edge. The read pointer increments and occupancy decrements.
- Latency: a word pushed at edge k is visible on outN_data with outN_valid=1 after edge k (first possible pop at edge k+1). No same-cycle bypass.
- Simultaneous push and pop on the same FIFO in one edge:
  - both take effect; occupancy is unchanged; order is preserved.
  - Allowed only when not full (in_ready already 0 when full).
- Full: occ=DEPTH. in_ready=0 for that sel; further words are held upstream, never dropped.
- Empty: occ=0. outN_valid=0 and outN_data forced to 0; outN_ready is ignored.
- Pointers: width $clog2(DEPTH), wrapping from DEPTH-1 to 0. Occupancy saturates at neither end: overflow and underflow are impossible by the rules above.
- Ordering: FIFO order per output. No ordering guarantee is made across outputs.
- in_valid=0: in_sel and in_data are don't-care; no state change on the input side.
- X on in_sel while in_valid=0 must not propagate into state.

Test Plan:
- Reset release, no traffic -> in_ready=1, both valid=0, data=0, occ0=occ1=0. Assert rst_n=0 with 2 words queued -> valid drops in the same cycle, occ returns to 0.
- Push 0xA5 sel=0 then 0x3C sel=1, both readies=1 -> out0 shows 0xA5 one cycle after its push, out1 shows 0x3C one cycle after its push. Each valid is high for exactly 1 cycle.
- out0_ready=0, push 0x11, 0x22 sel=0 -> occ0=2 and in_ready=0 for sel=0. A sel=1 word 0x33 is still accepted and appears on out1.
- Out0 full (0x11, 0x22), then raise out0_ready -> 0x11 popped, then 0x22. in_ready for sel=0 returns to 1 one cycle after the first pop.
- Steady stream sel=1 with out1_ready=1, occ1=1, simultaneous push and pop for 8 cycles -> occ1 stays 1. Words 0x00..0x07 exit in order with pointer wrap exercised.
- Random 1000-word traffic with random readies -> per-output scoreboard matches in order; no loss or duplication; occ never exceeds DEPTH.
